ras_stack: RTL and testbench

Return address stack for the fetch stage. It consumes the call/return classification and retired-branch indications produced by the branch predictor, and supplies a predicted return target. Pushes and pops are speculative. A small FIFO of pointer checkpoints, one per outstanding predicted branch, lets the stack pointer be restored on a branch misprediction flush.

---
 rtl/ras_stack.sv | 175 +++++++++++++++++
 tb/tb_ras_stack.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// ras_stack: speculative return address stack for the fetch stage.
//
// Calls push their return address and returns pop the top entry, both
// speculatively. Each outstanding predicted branch records a checkpoint of the
// stack pointer state {read_index, count} in a small FIFO. On a misprediction
// flush, the pointer state is restored from the oldest checkpoint. Stack
// contents are never restored.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   push           in   call fetched; push new_addr
//   pop            in   return fetched; pop top
//   new_addr       in   return address to push (call pc + 4)
//   addr           out  predicted return address (current top entry)
//   valid          out  stack holds at least one entry
//   branch_fetched in   predicted branch fetched; record a checkpoint
//   branch_retired in   oldest branch resolved without flush; drop oldest checkpoint
//   branch_flush   in   misprediction; restore pointer state from oldest checkpoint
//   ckpt_full      out  checkpoint FIFO holds TRACK_DEPTH entries

module ras_stack #(
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned TRACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] new_addr,
  output logic [31:0] addr,
  output logic        valid,
  input  logic        branch_fetched,
  input  logic        branch_retired,
  input  logic        branch_flush,
  output logic        ckpt_full
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned PtrW = $clog2(TRACK_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  localparam logic [CntW-1:0] CntMax = CntW'(ENTRIES);
  localparam logic [OccW-1:0] OccMax = OccW'(TRACK_DEPTH);

  typedef struct packed {
    logic [IdxW-1:0] idx;
    logic [CntW-1:0] cnt;
  } ckpt_t;

  // Stack storage and pointer state
  logic [31:0]     stack_q [ENTRIES];
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stack_we;
  logic [IdxW-1:0] stack_waddr;

  // Checkpoint FIFO
  ckpt_t           ckpt_q [TRACK_DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            fifo_empty, fifo_full;
  logic            enq, deq;
  ckpt_t           oldest;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OccMax);
  assign oldest     = ckpt_q[head_q];

  // Stack pointer next state
  always_comb begin
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stack_we    = 1'b0;
    stack_waddr = idx_q;

    if (branch_flush) begin
      // Restore pointer state only; anything pushed speculatively stays written.
      if (!fifo_empty) begin
        idx_d = oldest.idx;
        cnt_d = oldest.cnt;
      end
    end else if (push && pop) begin
      // Tail call: replace the top entry in place.
      stack_we    = 1'b1;
      stack_waddr = idx_q;
      if (cnt_q == '0) begin
        cnt_d = CntW'(1);
      end
    end else if (push) begin
      // Wraps over the oldest entry when the stack is already full.
      stack_we    = 1'b1;
      stack_waddr = idx_q + IdxW'(1);
      idx_d       = idx_q + IdxW'(1);
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop) begin
      if (cnt_q != '0) begin
        idx_d = idx_q - IdxW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Checkpoint FIFO next state
  always_comb begin
    deq    = !branch_flush && branch_retired && !fifo_empty;
    // A retire in the same cycle frees the slot a full FIFO needs.
    enq    = !branch_flush && branch_fetched && (!fifo_full || deq);
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;

    if (branch_flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      if (enq) begin
        tail_d = tail_q + PtrW'(1);
      end
      unique case ({enq, deq})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      if (stack_we) begin
        stack_q[stack_waddr] <= new_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        ckpt_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      // Snapshot is the post-update pointer state of this same cycle.
      if (enq) begin
        ckpt_q[tail_q] <= '{idx: idx_d, cnt: cnt_d};
      end
    end
  end

  assign addr      = stack_q[idx_q];
  assign valid     = (cnt_q != '0);
  assign ckpt_full = fifo_full;

endmodule

// File: tb/tb_ras_stack.sv
module tb_ras_stack;

  localparam int unsigned E  = 8;
  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop;
  logic [31:0] new_addr;
  logic [31:0] addr;
  logic        valid;
  logic        branch_fetched, branch_retired, branch_flush;
  logic        ckpt_full;

  always #5 clk = ~clk;

  ras_stack #(
    .ENTRIES    (E),
    .TRACK_DEPTH(TD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .pop           (pop),
    .new_addr      (new_addr),
    .addr          (addr),
    .valid         (valid),
    .branch_fetched(branch_fetched),
    .branch_retired(branch_retired),
    .branch_flush  (branch_flush),
    .ckpt_full     (ckpt_full)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic check_outs(input string name, input logic [31:0] ea, input logic ev,
                            input logic ef);
    check({name, ".addr"}, addr, ea);
    check({name, ".valid"}, {31'd0, valid}, {31'd0, ev});
    check({name, ".ckpt_full"}, {31'd0, ckpt_full}, {31'd0, ef});
  endtask

  // Present inputs for one cycle; returns 1 time unit after the rising edge.
  task automatic apply(input logic p, input logic po, input logic [31:0] na, input logic f,
                       input logic r, input logic fl);
    push           = p;
    pop            = po;
    new_addr       = na;
    branch_fetched = f;
    branch_retired = r;
    branch_flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic p, input logic po, input logic [31:0] na,
                      input logic f, input logic r, input logic fl, input logic [31:0] ea,
                      input logic ev, input logic ef);
    apply(p, po, na, f, r, fl);
    check_outs(name, ea, ev, ef);
  endtask

  // Vector table
  typedef struct {
    logic        p, po;
    logic [31:0] na;
    logic        f, r, fl;
    logic [31:0] ea;
    logic        ev, ef;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic po, input logic [31:0] na,
                              input logic [31:0] ea, input logic ev);
    vec_t v;
    v.p = p; v.po = po; v.na = na; v.f = 1'b0; v.r = 1'b0; v.fl = 1'b0;
    v.ea = ea; v.ev = ev; v.ef = 1'b0;
    return v;
  endfunction

  // Reference model: logical stack over a circular array, queue of snapshots
  typedef struct {
    int top;
    int cnt;
  } snap_t;

  logic [31:0] m_mem[E];
  int          m_top, m_cnt;
  snap_t       m_q[$];

  task automatic model_reset();
    for (int i = 0; i < E; i++) m_mem[i] = 32'd0;
    m_top = 0;
    m_cnt = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic p, input logic po, input logic [31:0] na, input logic f,
                            input logic r, input logic fl);
    int n;
    snap_t s;
    if (fl) begin
      if (m_q.size() > 0) begin
        m_top = m_q[0].top;
        m_cnt = m_q[0].cnt;
      end
      m_q.delete();
    end else begin
      if (p && po) begin
        m_mem[m_top] = na;
        if (m_cnt == 0) m_cnt = 1;
      end else if (p) begin
        m_top = (m_top + 1) % E;
        m_mem[m_top] = na;
        m_cnt = (m_cnt < E) ? m_cnt + 1 : E;
      end else if (po && m_cnt > 0) begin
        m_top = (m_top + E - 1) % E;
        m_cnt = m_cnt - 1;
      end
      n = m_q.size();
      if (r && n > 0) void'(m_q.pop_front());
      if (f && (n < TD || (r && n > 0))) begin
        s.top = m_top;
        s.cnt = m_cnt;
        m_q.push_back(s);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    push = 0; pop = 0; new_addr = 0;
    branch_fetched = 0; branch_retired = 0; branch_flush = 0;
    #3;
    check_outs("reset", 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic push/pop, underflow
    vecs.push_back(mk(1, 0, 32'h100, 32'h100, 1));
    vecs.push_back(mk(1, 0, 32'h200, 32'h200, 1));
    vecs.push_back(mk(0, 1, 32'h0, 32'h100, 1));
    vecs.push_back(mk(0, 1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0, 32'h0, 0));
    // Push after extra pop lands at slot 1: index did not move
    vecs.push_back(mk(1, 0, 32'h300, 32'h300, 1));
    vecs.push_back(mk(0, 1, 32'h0, 32'h0, 0));
    // Overflow: nine pushes into eight entries; slot 1 wraps to 0x90
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(1, 0, 32'(i * 16), 32'(i * 16), 1));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(0, 1, 32'h0, 32'(144 - 16 * k), 1));
    vecs.push_back(mk(0, 1, 32'h0, 32'h90, 0));
    // Tail call
    vecs.push_back(mk(1, 0, 32'hA0, 32'hA0, 1));
    vecs.push_back(mk(1, 1, 32'hB0, 32'hB0, 1));
    vecs.push_back(mk(0, 1, 32'h0, 32'h90, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].p, vecs[i].po, vecs[i].na, vecs[i].f, vecs[i].r, vecs[i].fl);
      check_outs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ev, vecs[i].ef);
    end

    // Checkpoint with push, speculative pushes/pops, flush restore
    step("ck_push", 1, 0, 32'h40, 1, 0, 0, 32'h40, 1, 0);
    step("ck_push2", 1, 0, 32'h50, 0, 0, 0, 32'h50, 1, 0);
    step("ck_pop1", 0, 1, 32'h0, 0, 0, 0, 32'h40, 1, 0);
    step("ck_pop2", 0, 1, 32'h0, 0, 0, 0, 32'h90, 0, 0);
    step("ck_flush", 0, 0, 32'h0, 0, 0, 1, 32'h40, 1, 0);

    // FIFO fill, drop, simultaneous retire+fetch, drain, extra retire
    for (int i = 0; i < 4; i++)
      step($sformatf("fill%0d", i), 0, 0, 0, 1, 0, 0, 32'h40, 1, (i == 3));
    step("fetch_full", 0, 0, 0, 1, 0, 0, 32'h40, 1, 1);
    step("ret_fetch", 0, 0, 0, 1, 1, 0, 32'h40, 1, 1);
    for (int i = 0; i < 4; i++)
      step($sformatf("drain%0d", i), 0, 0, 0, 0, 1, 0, 32'h40, 1, 0);
    step("extra_ret", 0, 0, 0, 0, 1, 0, 32'h40, 1, 0);
    // Occupancy must not have underflowed: full again after exactly four
    for (int i = 0; i < 4; i++)
      step($sformatf("refill%0d", i), 0, 0, 0, 1, 0, 0, 32'h40, 1, (i == 3));

    // Flush clears FIFO; flush on empty FIFO ignores push/pop
    step("flush_full", 0, 0, 0, 0, 0, 1, 32'h40, 1, 0);
    step("flush_empty", 1, 0, 32'hDEAD, 1, 0, 1, 32'h40, 1, 0);
    step("flush_pop", 0, 1, 32'h0, 0, 0, 1, 32'h40, 1, 0);
    step("post_push", 1, 0, 32'h77, 1, 0, 0, 32'h77, 1, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("fill_b%0d", i), 0, 0, 0, 1, 0, 0, 32'h77, 1, (i == 2));

    // Asynchronous reset between edges
    apply(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("after_rst", 0, 1, 0, 0, 1, 0, 32'd0, 1'b0, 1'b0);

    // Randomized run against reference model (DUT is at reset state here)
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      logic p, po, f, r, fl;
      logic [31:0] na;
      p  = ($urandom_range(99) < 40);
      po = ($urandom_range(99) < 40);
      f  = ($urandom_range(99) < 35);
      r  = ($urandom_range(99) < 25);
      fl = ($urandom_range(99) < 5);
      na = $urandom;
      apply(p, po, na, f, r, fl);
      model_step(p, po, na, f, r, fl);
      check_outs($sformatf("rnd%0d", c), m_mem[m_top], (m_cnt != 0), (m_q.size() == TD));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
